// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared state encoding and bus geometry for sram_ctrl
package sram_ctrl_pkg;

    localparam int READ_BEATS  = 4;
    localparam int WRITE_BEATS = 2;
    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int BEAT_W      = 2;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        DONE,
        TURN
    } state_t;

endpackage

// File: rtl/sram_beat_timer.sv
// rtl/sram_beat_timer.sv - wait-state counter and beat index for SRAM beats
module sram_beat_timer
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    input  logic [BEAT_W-1:0] last_beat,
    output logic [BEAT_W-1:0] beat,
    output logic              beat_last_cycle,
    output logic              beat_done
);

    localparam int WAIT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);

    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wait_cnt <= '0;
            beat     <= '0;
        end else if (advance) begin
            if (beat_last_cycle) begin
                wait_cnt <= '0;
                beat     <= beat + 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // wait_cnt counts cycles already spent in the beat currently on the pins
    assign beat_last_cycle = (wait_cnt == WAIT_LAST);
    assign beat_done       = beat_last_cycle && (beat == last_beat);

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - cache-to-async-SRAM sequencer; optional stats via SRAM_CTRL_STATS_EN
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            address,
    input  logic [31:0]            write_data,
    input  logic                   mem_read,
    input  logic                   mem_write,
    output logic [63:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic [15:0]            rd_count,
    output logic [15:0]            wr_count
);

    // With no wait states there is no setup cycle, so WE# drops immediately
    localparam logic SETUP_WE_N = (WAIT_CYCLES != 0);

    state_t            state;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] next_beat;
    logic [BEAT_W-1:0] last_beat;
    logic              beat_last_cycle;
    logic              beat_done;

    assign last_beat = (state == WRITE) ? BEAT_W'(WRITE_BEATS - 1) : BEAT_W'(READ_BEATS - 1);
    assign next_beat = beat + 1'b1;

    sram_beat_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_timer (
        .clk            (clk),
        .rst            (rst),
        .clear          (state == IDLE),
        .advance        ((state == READ) || (state == WRITE)),
        .last_beat      (last_beat),
        .beat           (beat),
        .beat_last_cycle(beat_last_cycle),
        .beat_done      (beat_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            ready       <= 1'b0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_write) begin
                        state       <= WRITE;
                        sram_addr   <= {1'b0, address, 1'b0};
                        sram_dq_out <= write_data[15:0];
                        sram_dq_oe  <= 1'b1;
                        sram_we_n   <= SETUP_WE_N;
                    end else if (mem_read) begin
                        state     <= READ;
                        sram_addr <= {1'b0, address[15:1], 2'b00};
                        sram_oe_n <= 1'b0;
                    end
                end
                READ: begin
                    if (beat_last_cycle) begin
                        read_data[{beat, 4'b0000} +: SRAM_DATA_W] <= sram_dq_in;
                        if (beat_done) begin
                            state     <= DONE;
                            ready     <= 1'b1;
                            sram_oe_n <= 1'b1;
                        end else begin
                            sram_addr <= {1'b0, address[15:1], next_beat};
                        end
                    end
                end
                WRITE: begin
                    if (beat_last_cycle) begin
                        if (beat_done) begin
                            state      <= DONE;
                            ready      <= 1'b1;
                            sram_we_n  <= 1'b1;
                            sram_dq_oe <= 1'b0;
                        end else begin
                            sram_addr   <= {1'b0, address, next_beat[0]};
                            sram_dq_out <= write_data[{next_beat[0], 4'b0000} +: SRAM_DATA_W];
                            sram_we_n   <= SETUP_WE_N;
                        end
                    end else begin
                        sram_we_n <= 1'b0;
                    end
                end
                DONE:    state <= TURN;
                TURN:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SRAM_CTRL_STATS_EN
    logic rd_fin;
    logic wr_fin;

    assign rd_fin = (state == READ) && beat_done;
    assign wr_fin = (state == WRITE) && beat_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_fin && (rd_count != 16'hFFFF)) rd_count <= rd_count + 1'b1;
            if (wr_fin && (wr_count != 16'hFFFF)) wr_count <= wr_count + 1'b1;
        end
    end
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Sequencing controller between the data cache's line-fill/write-through port and the external 16-bit asynchronous SRAM. Converts one 64-bit line read request into four 16-bit SRAM beats and one 32-bit word write into two beats, inserting configurable wait states. Returns the assembled line with a one-cycle `ready` pulse. Sits directly below the cache in the MEM stage and is the only master of the SRAM pins.

## Interface
Parameters:
- `WAIT_CYCLES`, 1, extra cycles per SRAM beat; beat length = WAIT_CYCLES+1 cycles; legal 0..7.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: synchronous, active-low reset.
- `address` in 16: 32-bit word address from cache.
- `write_data` in 32: word to write.
- `mem_read` in 1: line read request, level, held until `ready`.
- `mem_write` in 1: word write request, level, held until `ready`.
- `read_data` out 64: assembled line, valid when `ready`=1, held until next read completes.
- `ready` out 1: one-cycle completion pulse.
- `sram_addr` out 18: SRAM halfword address.
- `sram_dq_in` in 16: SRAM data bus, read side.
- `sram_dq_out` out 16: SRAM data bus, write side.
- `sram_dq_oe` out 1: tristate enable for `sram_dq_out`.
- `sram_we_n` out 1: SRAM write enable, active-low.
- `sram_oe_n` out 1: SRAM output enable, active-low.
- `rd_count`, `wr_count` out 16 each: completed-transaction counters (see Configuration).

## Operation
- FSM states: IDLE, READ, WRITE, DONE, TURN. Requests sampled only in IDLE.
- IDLE: `mem_write`=1 → WRITE (write wins if both asserted; read stays pending). `mem_read`=1 → READ. Beat and wait counters are cleared on entry.
- READ: 4 beats, beat b=0..3. `sram_addr`={1'b0, address[15:1], b[1:0]}. `sram_oe_n`=0 and `sram_dq_oe`=0 throughout. `sram_dq_in` is captured at the edge ending each beat into `read_data[16b+15:16b]` (little-endian). After beat 3 → DONE.
- WRITE: 2 beats, b=0..1. `sram_addr`={1'b0, address[15:0], b[0]}. `sram_dq_out`=`write_data[16b+15:16b]` and `sram_dq_oe`=1 for the whole beat.
  - `sram_we_n`=0 for the whole beat if WAIT_CYCLES=0.
  - Otherwise `sram_we_n`=1 in the first cycle of each beat (address setup) and 0 for the remaining cycles.
  - After beat 1 → DONE.
- DONE: `ready`=1 for exactly one cycle. All SRAM controls are inactive. Always → TURN.
- TURN: one bus-turnaround cycle. Requests are ignored. Always → IDLE. The requester must drop its request in the cycle after `ready`.
- A write leaves `read_data` unchanged.
- `address` and `write_data` must be stable while the request is held. The controller does not latch them.

## Timing
- Reset values (cycle after `rst`=0 sampled): state IDLE, `ready`=0, `read_data`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1, `sram_oe_n`=1, counters 0.
- Reset mid-transaction aborts at the next edge: `sram_we_n`=1, no `ready`, no partial `read_data` update after reset.
- All outputs are registered.
- Read latency: request sampled at edge k; `ready` high in cycle k+1+4(WAIT_CYCLES+1). For WAIT_CYCLES=1: 9 cycles.
- Write latency: `ready` high in cycle k+1+2(WAIT_CYCLES+1). For WAIT_CYCLES=1: 5 cycles.
- Minimum request-to-request spacing is the latency plus 2 cycles (DONE, TURN).

## Configuration
- `SRAM_CTRL_STATS_EN` defined:
  - `rd_count` increments on each read DONE.
  - `wr_count` increments on each write DONE.
  - Both are 16-bit, saturate at 0xFFFF, and reset to 0.
- Undefined: both ports tied to 0 and no counter logic is generated. Port list is unchanged.

## Structure
- Shared package `sram_ctrl_pkg`: FSM state encoding, READ_BEATS=4, WRITE_BEATS=2, SRAM_ADDR_W=18, SRAM_DATA_W=16.
- One sub-module, `sram_beat_timer`:
  - Function: wait-state counter plus beat index.
  - Outputs: `beat_last_cycle` and `beat_done`.
  - Parameterised by WAIT_CYCLES.
- The top level holds the FSM, datapath muxing and optional counters.

## Test plan
- Reset, then idle 5 cycles → `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0, `ready`=0 throughout.
- WAIT_CYCLES=1, read `address`=0x0013, SRAM model returns halfword addr[15:0] → `sram_addr` sequence 0x24, 0x25, 0x26, 0x27, 2 cycles each; `ready` 9 cycles after request; `read_data`=0x0027_0026_0025_0024.
- WAIT_CYCLES=1, write `address`=0x0100, `write_data`=0xDEAD_BEEF → beats at `sram_addr` 0x200 (0xBEEF), then 0x201 (0xDEAD); `sram_we_n` low only in the 2nd cycle of each beat; `ready` at cycle 5.
- `mem_read` and `mem_write` asserted together → write done first. Read starts after TURN and `ready` pulses twice in total. With the stats macro defined, `wr_count`=1 and `rd_count`=1.
- `rst`=0 asserted during read beat 2 → next cycle `sram_oe_n`=1, state IDLE, no `ready`. A following read completes normally.
- WAIT_CYCLES=0 read → `ready` 5 cycles after request; `sram_we_n` stays 1.
